snn_frame_packer: RTL and testbench

Sits between the SNN motion detector and the Ascon-128 AEAD core. On every completed frame it captures the detector's result into one 64-bit record and buffers it in a small FIFO. It groups FRAMES_PER_MSG records into one AEAD message: it pulses the cipher's start-encrypt, streams the records over a valid/ready port with last on the final block, then waits for the tag. Motion telemetry is thereby sealed in-chip before it leaves the tile.

---
 rtl/snn_frame_packer.sv | 187 ++++++++++++++++++
 tb/tb_snn_frame_packer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_frame_packer.sv
// snn_frame_packer: seals SNN detector frames as 64-bit records into AEAD messages.
// Optional build macro PACKER_MOTION_ONLY_EN: enqueue only frames with motion.
module snn_frame_packer #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned FRAMES_PER_MSG = 4,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        frame_done,
    input  logic        motion_detected,
    input  logic [7:0]  motion_intensity,
    input  logic [15:0] grid_activity,
    input  logic [15:0] event_count,
    input  logic        ascon_busy,
    input  logic        ascon_tag_valid,
    output logic        start_encrypt,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [63:0] m_tdata,
    output logic        m_tlast,
    output logic        msg_active,
    output logic [3:0]  fifo_level,
    output logic [7:0]  drop_count
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LVL_MAX  = 4'(DEPTH);
    localparam logic [3:0]  LAST_BLK = 4'(FRAMES_PER_MSG - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        STREAM,
        WAIT_TAG
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [3:0]    level;
    logic [7:0]    frame_seq;
    logic          drop_flag;
    logic [7:0]    drops;
    logic [3:0]    blk_cnt;

    logic          frame_in;
    logic          eligible;
    logic          has_room;
    logic          push;
    logic          drop;
    logic          pop;
    logic          fire;
    logic          last_blk;
    logic [7:0]    flags;
    logic [63:0]   record;

    assign frame_in = frame_done && enable;

`ifdef PACKER_MOTION_ONLY_EN
    assign eligible = frame_in && motion_detected;
`else
    assign eligible = frame_in;
`endif

    // pop is derived from state directly so the handshake has no comb loop
    assign pop      = (state == STREAM) && (level != 4'd0) && m_tready;
    assign fire     = (state == START) && !ascon_busy;
    assign last_blk = (blk_cnt == LAST_BLK);
    assign has_room = (level < LVL_MAX) || pop;
    assign push     = eligible && has_room;
    assign drop     = eligible && !has_room;

    assign flags  = {motion_detected, drop_flag, 6'b0};
    assign record = {SYNC_BYTE, frame_seq, flags, motion_intensity,
                     grid_activity, event_count};

    assign m_tdata    = mem[rd_ptr];
    assign fifo_level = level;
    assign drop_count = drops;

    // record FIFO: storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= record;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 4'd1;
                2'b01:   level <= level - 4'd1;
                default: level <= level;
            endcase
        end
    end

    // frame sequence, sticky drop flag and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_seq <= '0;
            drop_flag <= 1'b0;
            drops     <= '0;
        end else begin
            if (frame_in) begin
                frame_seq <= frame_seq + 8'd1;
            end
            if (push) begin
                drop_flag <= 1'b0;
            end else if (drop) begin
                drop_flag <= 1'b1;
            end
            if (drop && (drops != 8'hFF)) begin
                drops <= drops + 8'd1;
            end
        end
    end

    // block counter within the current message
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (fire) begin
            blk_cnt <= '0;
        end else if (pop) begin
            blk_cnt <= blk_cnt + 4'd1;
        end
    end

    // message FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // message FSM next state and handshake outputs
    always_comb begin
        state_nxt     = state;
        start_encrypt = 1'b0;
        m_tvalid      = 1'b0;
        m_tlast       = 1'b0;
        msg_active    = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (level != 4'd0) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (!ascon_busy) begin
                    start_encrypt = 1'b1;
                    state_nxt     = STREAM;
                end
            end
            STREAM: begin
                m_tvalid = (level != 4'd0);
                m_tlast  = last_blk;
                if (pop && last_blk) begin
                    state_nxt = WAIT_TAG;
                end
            end
            WAIT_TAG: begin
                if (ascon_tag_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_snn_frame_packer.sv
// tb_snn_frame_packer: directed and random checks of snn_frame_packer
// against a queue-based reference model of the record stream.
module tb_snn_frame_packer;

    localparam int DEPTH = 4;
    localparam int FPM   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        frame_done;
    logic        motion_detected;
    logic [7:0]  motion_intensity;
    logic [15:0] grid_activity;
    logic [15:0] event_count;
    logic        ascon_busy;
    logic        ascon_tag_valid;
    logic        start_encrypt;
    logic        m_tvalid;
    logic        m_tready;
    logic [63:0] m_tdata;
    logic        m_tlast;
    logic        msg_active;
    logic [3:0]  fifo_level;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    snn_frame_packer #(
        .DEPTH(DEPTH),
        .FRAMES_PER_MSG(FPM),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .frame_done(frame_done),
        .motion_detected(motion_detected),
        .motion_intensity(motion_intensity),
        .grid_activity(grid_activity),
        .event_count(event_count),
        .ascon_busy(ascon_busy),
        .ascon_tag_valid(ascon_tag_valid),
        .start_encrypt(start_encrypt),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tdata(m_tdata),
        .m_tlast(m_tlast),
        .msg_active(msg_active),
        .fifo_level(fifo_level),
        .drop_count(drop_count)
    );

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q[$];
    logic [63:0] seen[$];
    int          m_seq;
    int          m_drops;
    bit          m_flag;
    int          m_blk;
    bit          msg_open;
    bit          await_tag;
    int          starts;
    bit          prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_seq      = 0;
        m_drops    = 0;
        m_flag     = 0;
        m_blk      = 0;
        msg_open   = 0;
        await_tag  = 0;
        prev_stall = 0;
        prev_data  = '0;
        prev_last  = 0;
    endtask

    // one clock: observe the cycle, update the model, step, check counters
    task automatic tick();
        logic        hs;
        bit          room;
        bit          elig;
        logic [63:0] rec;
        #1;
        hs = m_tvalid && m_tready;
        if (prev_stall) begin
            chk("hold_valid", 64'(m_tvalid), 64'(1));
            chk("hold_data", m_tdata, prev_data);
            chk("hold_last", 64'(m_tlast), 64'(prev_last));
        end
        if (start_encrypt) begin
            starts++;
            chk("start_legal", 64'({msg_open, await_tag, ascon_busy}), 64'(0));
            msg_open = 1;
            m_blk    = 0;
        end
        if (m_tvalid) begin
            chk("valid_in_msg", 64'(msg_open), 64'(1));
        end
        if (ascon_tag_valid && await_tag) begin
            await_tag = 0;
        end
        room = (exp_q.size() < DEPTH) || hs;
        if (hs) begin
            chk("pop_nonempty", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                rec = exp_q.pop_front();
                chk("tdata", m_tdata, rec);
            end
            chk("tlast", 64'(m_tlast), 64'(m_blk == FPM - 1));
            seen.push_back(m_tdata);
            if (m_blk == FPM - 1) begin
                msg_open  = 0;
                await_tag = 1;
                m_blk     = 0;
            end else begin
                m_blk++;
            end
        end
        if (frame_done && enable) begin
            elig = 1;
`ifdef PACKER_MOTION_ONLY_EN
            elig = motion_detected;
`endif
            if (elig) begin
                if (room) begin
                    exp_q.push_back({8'hA5, 8'(m_seq), motion_detected, m_flag,
                                     6'b0, motion_intensity, grid_activity,
                                     event_count});
                    m_flag = 0;
                end else begin
                    m_flag = 1;
                    if (m_drops < 255) m_drops++;
                end
            end
            m_seq = (m_seq + 1) % 256;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        @(posedge clk);
        #1;
        chk("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
    endtask

    task automatic do_reset();
        rst_n            = 0;
        enable           = 1;
        frame_done       = 0;
        motion_detected  = 0;
        motion_intensity = '0;
        grid_activity    = '0;
        event_count      = '0;
        ascon_busy       = 0;
        ascon_tag_valid  = 0;
        m_tready         = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start", 64'(start_encrypt), 64'(0));
        chk("rst_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_tdata", m_tdata, 64'(0));
        chk("rst_tlast", 64'(m_tlast), 64'(0));
        chk("rst_active", 64'(msg_active), 64'(0));
        chk("rst_level", 64'(fifo_level), 64'(0));
        chk("rst_drops", 64'(drop_count), 64'(0));
        model_reset();
        rst_n = 1;
    endtask

    task automatic send_frame(input logic mot, input logic [7:0] inten);
        frame_done       = 1;
        motion_detected  = mot;
        motion_intensity = inten;
        grid_activity    = 16'($urandom);
        event_count      = 16'($urandom);
        tick();
        frame_done = 0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!m_tvalid && n < budget) begin
            tick();
            n++;
        end
        chk("wait_valid", 64'(m_tvalid), 64'(1));
    endtask

    task automatic close_msg(input int budget);
        int n = 0;
        m_tready   = 1;
        ascon_busy = 0;
        while (!await_tag && n < budget) begin
            tick();
            n++;
        end
        chk("close_timeout", 64'(await_tag), 64'(1));
        ascon_tag_valid = 1;
        tick();
        ascon_tag_valid = 0;
        chk("idle_after_tag", 64'(msg_active), 64'(0));
    endtask

    initial begin
        logic [63:0] held;
        logic [3:0]  lvl;

        // basic message of four records
        do_reset();
        m_tready = 1;
        seen.delete();
        starts = 0;
        for (int i = 0; i < 4; i++) begin
            frame_done       = 1;
            motion_detected  = 1;
            motion_intensity = 8'(8'h10 + i);
            grid_activity    = 16'($urandom);
            event_count      = 16'($urandom);
            tick();
            if (i == 0) begin
                chk("enq_level_n1", 64'(fifo_level), 64'(1));
                chk("idle_n1", 64'(msg_active), 64'(0));
            end
            if (i == 1) chk("start_n2", 64'(start_encrypt), 64'(1));
            if (i == 2) chk("valid_n3", 64'(m_tvalid), 64'(1));
        end
        frame_done = 0;
        close_msg(50);
        chk("one_start", 64'(starts), 64'(1));
        chk("four_records", 64'(seen.size()), 64'(4));
        for (int j = 0; j < seen.size(); j++) begin
            chk("hdr", 64'(seen[j][63:56]), 64'(8'hA5));
            chk("seq", 64'(seen[j][55:48]), 64'(j));
            chk("inten", 64'(seen[j][39:32]), 64'(8'h10 + j));
        end

        // backpressure keeps the head record stable
        m_tready = 0;
        send_frame(1'b0, 8'h33);
        wait_valid(10);
        held = m_tdata;
        lvl  = fifo_level;
        repeat (5) begin
            tick();
            chk("bp_valid", 64'(m_tvalid), 64'(1));
            chk("bp_data", m_tdata, held);
            chk("bp_level", 64'(fifo_level), 64'(lvl));
        end
        repeat (3) send_frame(1'b1, 8'($urandom));
        close_msg(50);

        // busy cipher holds off start_encrypt
        starts     = 0;
        ascon_busy = 1;
        send_frame(1'b1, 8'h44);
        repeat (6) tick();
        chk("no_start_busy", 64'(starts), 64'(0));
        chk("active_busy", 64'(msg_active), 64'(1));
        ascon_busy = 0;
        #1;
        chk("start_release", 64'(start_encrypt), 64'(1));
        tick();
        chk("start_pulse", 64'(start_encrypt), 64'(0));
        chk("start_once", 64'(starts), 64'(1));
        repeat (3) send_frame(1'b1, 8'($urandom));
        close_msg(50);

        // overflow while the cipher stays busy
        do_reset();
        ascon_busy = 1;
        m_tready   = 1;
        repeat (6) send_frame(1'b1, 8'($urandom));
        chk("ovf_level", 64'(fifo_level), 64'(4));
        chk("ovf_drops", 64'(drop_count), 64'(2));
        ascon_busy = 0;
        wait_valid(10);
        send_frame(1'b0, 8'h66);
        chk("full_push_pop", 64'(fifo_level), 64'(4));
        close_msg(50);
        wait_valid(10);
        chk("next_seq", 64'(m_tdata[55:48]), 64'(6));
        chk("next_dflag", 64'(m_tdata[46]), 64'(1));

        // long drop run: seq wrap and counter saturation
        do_reset();
        ascon_busy = 1;
        for (int i = 0; i < 300; i++) begin
            frame_done       = 1;
            motion_detected  = 1;
            motion_intensity = 8'($urandom);
            grid_activity    = 16'($urandom);
            event_count      = 16'($urandom);
            tick();
        end
        frame_done = 0;
        chk("sat_drops", 64'(drop_count), 64'(255));
        close_msg(50);
        send_frame(1'b1, 8'h77);
        wait_valid(10);
        chk("wrap_seq", 64'(m_tdata[55:48]), 64'(300 % 256));
        chk("wrap_dflag", 64'(m_tdata[46]), 64'(1));
        repeat (3) send_frame(1'b1, 8'($urandom));
        close_msg(50);

        // alternating motion flags
        do_reset();
        m_tready = 1;
        seen.delete();
        for (int i = 0; i < 8; i++) begin
            send_frame(1'(i % 2), 8'(i));
        end
`ifdef PACKER_MOTION_ONLY_EN
        close_msg(50);
        chk("mo_count", 64'(seen.size()), 64'(4));
        for (int j = 0; j < seen.size(); j++) begin
            chk("mo_odd", 64'(seen[j][48]), 64'(1));
            chk("mo_flag7", 64'(seen[j][47]), 64'(1));
        end
`else
        close_msg(50);
        close_msg(50);
        chk("all_count", 64'(seen.size()), 64'(8));
        for (int j = 0; j < seen.size(); j++) begin
            chk("all_flag7", 64'(seen[j][47]), 64'(j % 2));
        end
`endif
        chk("mo_drops", 64'(drop_count), 64'(0));

        // random traffic against the model, reset mid-message at the end
        do_reset();
        for (int i = 0; i < 600; i++) begin
            frame_done       = ($urandom % 3) == 0;
            enable           = ($urandom % 8) != 0;
            motion_detected  = 1'($urandom);
            motion_intensity = 8'($urandom);
            grid_activity    = 16'($urandom);
            event_count      = 16'($urandom);
            m_tready         = 1'($urandom);
            ascon_busy       = ($urandom % 4) == 0;
            ascon_tag_valid  = await_tag ? (($urandom % 3) == 0)
                                         : (($urandom % 16) == 0);
            tick();
        end
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
